// File: rtl/robo_seguidor_parede.sv
// Wall-following motion controller. A clock divider produces update ticks.
// On each enabled tick the front and side bump sensors are debounced, the
// wall side is sampled, and a five-state Moore FSM decides whether to drive
// forward, turn away from an obstacle, or arc back towards the wall. Too many
// consecutive turning ticks trigger a timed recovery manoeuvre.
module robo_seguidor_parede #(
  parameter int DIV_CYCLES = 3,
  parameter int DEB_LEN    = 2,
  parameter int MAX_GIROS  = 4,
  parameter int REC_TICKS  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       lado,
  input  logic       head,
  input  logic       wall,
  output logic       avancar,
  output logic       girar,
  output logic       sentido,
  output logic       preso,
  output logic [2:0] estado
);

  // Single-value counters still need one bit of storage.
  localparam int DIV_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam int DEB_W = (DEB_LEN    > 1) ? $clog2(DEB_LEN)    : 1;
  localparam int GIR_W = (MAX_GIROS  > 1) ? $clog2(MAX_GIROS)  : 1;
  localparam int REC_W = (REC_TICKS  > 1) ? $clog2(REC_TICKS)  : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_LEN - 1);
  localparam logic [GIR_W-1:0] GIR_LAST = GIR_W'(MAX_GIROS - 1);
  localparam logic [REC_W-1:0] REC_LOAD = REC_W'(REC_TICKS - 1);

  typedef enum logic [2:0] {
    PROCURA     = 3'd0,
    SEGUE       = 3'd1,
    GIRA_FORA   = 3'd2,
    GIRA_DENTRO = 3'd3,
    RECUPERA    = 3'd4
  } state_t;

  typedef struct packed {
    logic             filt;
    logic [DEB_W-1:0] cnt;
  } deb_t;

  // One debounce step: a raw value must disagree with the filtered value for
  // DEB_LEN consecutive ticks before the filtered value follows it.
  function automatic deb_t deb_step(input logic raw, input deb_t cur);
    deb_t nxt;
    nxt = cur;
    if (raw == cur.filt) begin
      nxt.cnt = '0;
    end else if (cur.cnt == DEB_LAST) begin
      nxt.filt = raw;
      nxt.cnt  = '0;
    end else begin
      nxt.cnt = cur.cnt + DEB_W'(1);
    end
    return nxt;
  endfunction

  logic [DIV_W-1:0] div_q,   div_d;
  deb_t             head_q,  head_d;
  deb_t             wall_q,  wall_d;
  logic             lado_q,  lado_d;
  state_t           state_q, state_d;
  logic [GIR_W-1:0] giros_q, giros_d;
  logic [REC_W-1:0] rec_q,   rec_d;

  logic   tick;
  logic   tick_en;
  state_t cand;

  // Divider: free-running whenever out of reset, independent of enable.
  always_comb begin
    tick    = (div_q == DIV_LAST);
    tick_en = tick & enable;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
  end

  // Sensor filters and side sample advance only on enabled ticks.
  always_comb begin
    head_d = head_q;
    wall_d = wall_q;
    lado_d = lado_q;
    if (tick_en) begin
      head_d = deb_step(head, head_q);
      wall_d = deb_step(wall, wall_q);
      lado_d = lado;
    end
  end

  // Next-state logic with turn counting and recovery timing; the FSM sees
  // the filtered values as updated on this same tick.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    giros_d = giros_q;
    rec_d   = rec_q;
    cand    = PROCURA;
    if (tick_en) begin
      if (state_q == RECUPERA) begin
        giros_d = '0;
        if (rec_q == '0) state_d = PROCURA;
        else             rec_d   = rec_q - REC_W'(1);
      end else begin
        if (head_d.filt)                                        cand = GIRA_FORA;
        else if (wall_d.filt)                                   cand = SEGUE;
        else if (state_q == SEGUE || state_q == GIRA_DENTRO)    cand = GIRA_DENTRO;
        else                                                    cand = PROCURA;

        if (cand == GIRA_FORA || cand == GIRA_DENTRO) begin
          if (giros_q == GIR_LAST) begin
            state_d = RECUPERA;
            giros_d = '0;
            rec_d   = REC_LOAD;
          end else begin
            state_d = cand;
            giros_d = giros_q + GIR_W'(1);
          end
        end else begin
          state_d = cand;
          giros_d = '0;
        end
      end
    end
  end

  // State register: asynchronous active-high reset clears everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      head_q  <= '0;
      wall_q  <= '0;
      lado_q  <= 1'b0;
      state_q <= PROCURA;
      giros_q <= '0;
      rec_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      div_q   <= div_d;
      head_q  <= head_d;
      wall_q  <= wall_d;
      lado_q  <= lado_d;
      state_q <= state_d;
      giros_q <= giros_d;
      rec_q   <= rec_d;
    end
  end

  // Moore outputs, forced to zero while in reset or disabled.
  always_comb begin
    avancar = 1'b0;
    girar   = 1'b0;
    sentido = 1'b0;
    preso   = 1'b0;
    estado  = 3'd0;
    if (!reset && enable) begin
      estado = state_q;
      unique case (state_q)
        PROCURA, SEGUE: begin
          avancar = 1'b1;
        end
        GIRA_FORA: begin
          girar   = 1'b1;
          sentido = ~lado_q;
        end
        GIRA_DENTRO: begin
          avancar = 1'b1;
          girar   = 1'b1;
          sentido = lado_q;
        end
        RECUPERA: begin
          girar   = 1'b1;
          sentido = ~lado_q;
          preso   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_robo_seguidor_parede.sv
// Directed bench for robo_seguidor_parede with default parameters.
// Outputs are packed as {0, estado[2:0], preso, sentido, girar, avancar}.
module tb_robo_seguidor_parede;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       lado;
  logic       head;
  logic       wall;
  logic       avancar;
  logic       girar;
  logic       sentido;
  logic       preso;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] OFF   = 8'h00;
  localparam logic [7:0] PROC  = 8'h01;
  localparam logic [7:0] SEG   = 8'h11;
  localparam logic [7:0] GF_L  = 8'h26;  // lado_q=0: turn right, away from wall
  localparam logic [7:0] GF_R  = 8'h22;  // lado_q=1: turn left
  localparam logic [7:0] GD_L  = 8'h33;  // lado_q=0: arc left, towards wall
  localparam logic [7:0] GD_R  = 8'h37;  // lado_q=1: arc right
  localparam logic [7:0] REC_L = 8'h4E;

  robo_seguidor_parede dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .lado    (lado),
    .head    (head),
    .wall    (wall),
    .avancar (avancar),
    .girar   (girar),
    .sentido (sentido),
    .preso   (preso),
    .estado  (estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp);
    check(tag, {1'b0, estado, preso, sentido, girar, avancar}, exp);
  endtask

  // One tick = three clocks; inputs change and outputs are sampled on negedges.
  task automatic step();
    repeat (3) @(negedge clock);
  endtask

  initial begin
    clock  = 1'b0;
    reset  = 1'b1;
    enable = 1'b1;
    lado   = 1'b0;
    head   = 1'b0;
    wall   = 1'b0;

    #1 chk_out("rst_hold", OFF);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1 chk_out("rst_release", PROC);
    step(); chk_out("idle_tick", PROC);

    // A one-tick wall glitch must not reach the FSM.
    wall = 1'b1; step(); chk_out("glitch_t1", PROC);
    wall = 1'b0; step(); chk_out("glitch_t2", PROC);
    step();              chk_out("glitch_t3", PROC);

    // Held wall: SEGUE on the second tick, not before the divider fires.
    wall = 1'b1; step(); chk_out("wall_t1", PROC);
    repeat (2) @(negedge clock);
    chk_out("div_mid", PROC);
    @(negedge clock);
    chk_out("wall_t2", SEG);

    // Obstacle ahead while following the left wall; h and w both high.
    head = 1'b1; step(); chk_out("head_l_t1", SEG);
    step();              chk_out("head_l_t2", GF_L);
    head = 1'b0; step(); chk_out("head_l_t3", GF_L);
    step();              chk_out("head_l_t4", SEG);

    // Same with right wall.
    lado = 1'b1; head = 1'b1;
    step();              chk_out("head_r_t1", SEG);
    step();              chk_out("head_r_t2", GF_R);
    head = 1'b0; step(); chk_out("head_r_t3", GF_R);
    step();              chk_out("head_r_t4", SEG);

    // Wall lost: arc back; lado change mid-turn flips sentido only.
    wall = 1'b0; step(); chk_out("lost_t1", SEG);
    step();              chk_out("lost_t2", GD_R);
    lado = 1'b0; step(); chk_out("lado_flip", GD_L);
    wall = 1'b1; step(); chk_out("regain_t1", GD_L);  // turn count now MAX-1
    step();              chk_out("regain_t2", SEG);   // leaves before recovery

    // Head held: 3 turning ticks, 2 recovery ticks, PROCURA, repeat.
    head = 1'b1; step(); chk_out("stuck_deb", SEG);
    step();              chk_out("stuck_gf1", GF_L);
    step();              chk_out("stuck_gf2", GF_L);
    step();              chk_out("stuck_gf3", GF_L);
    step();              chk_out("stuck_rec1", REC_L);
    step();              chk_out("stuck_rec2", REC_L);
    step();              chk_out("stuck_proc", PROC);
    step();              chk_out("stuck_again", GF_L);

    // Freeze mid-turn (one turning tick used), then resume.
    enable = 1'b0;
    #1 chk_out("dis_now", OFF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("dis_t%0d", i), OFF);
    end
    enable = 1'b1;
    #1 chk_out("en_resume", GF_L);
    step();              chk_out("resume_gf2", GF_L);
    step();              chk_out("resume_gf3", GF_L);
    step();              chk_out("resume_rec", REC_L);

    // Asynchronous reset mid-tick while in recovery.
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk_out("rst_async", OFF);
    @(negedge clock);
    reset = 1'b0;
    #1 chk_out("rst_rec_exit", PROC);
    step();              chk_out("post_rst_t1", PROC);
    step();              chk_out("post_rst_t2", GF_L);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/robo_seguidor_parede.md
Name: robo_seguidor_parede

Overview:
Parametrised wall-following motion controller for the robot.
- Successor to the fixed 2-state left-wall controller.
- Adds a configurable update divider, per-sensor debounce and selectable wall side (left/right).
- Adds turn-direction output and stuck detection with timed recovery.
- Sits between the raw front/side bump sensors and the motor driver.

Parameters:
DIV_CYCLES, 3, clock cycles per FSM update tick (>=1)
DEB_LEN, 2, consecutive ticks a raw sensor must disagree with its filtered value before the filtered value flips (>=1)
MAX_GIROS, 4, consecutive turning ticks that trigger recovery (>=2)
REC_TICKS, 2, ticks spent in recovery (>=1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = run; 0 = freeze FSM and filters, motors off
lado  input  1  wall side to follow: 0 = left, 1 = right; sampled on tick
head  input  1  raw front obstacle sensor
wall  input  1  raw side wall sensor (side selected by lado)
avancar  output  1  drive forward
girar  output  1  turn
sentido  output  1  turn direction: 0 = left, 1 = right; 0 when girar=0
preso  output  1  high while in recovery
estado  output  3  current state code

Behaviour:
- Reset (async, high) clears all registers: divider, debounce counters, filtered sensors, lado_q, turn counter, recovery counter; state = PROCURA.
- All outputs are 0 while reset=1 or enable=0, including avancar, girar, sentido, preso and estado.
- Divider: counter 0..DIV_CYCLES-1 runs whenever not in reset. A tick occurs on the edge where counter==DIV_CYCLES-1; the counter then wraps to 0. With DIV_CYCLES=1, every cycle is a tick.
- Nothing except the divider changes on a tick while enable=0. Held state resumes on the first tick with enable=1.
- Debounce (head and wall independently, on each enabled tick):
  - raw==filtered: agree counter cleared.
  - raw!=filtered: counter increments.
  - When the increment reaches DEB_LEN, the filtered value flips and the counter clears.
  - The FSM on the same tick uses the post-update filtered values (h, w).
- lado_q <= lado on each enabled tick; outputs use lado_q.
- States and codes: PROCURA=0, SEGUE=1, GIRA_FORA=2, GIRA_DENTRO=3, RECUPERA=4.
- Next state from PROCURA/SEGUE/GIRA_FORA/GIRA_DENTRO, in priority order:
  - h=1 -> GIRA_FORA.
  - else w=1 -> SEGUE.
  - else from SEGUE or GIRA_DENTRO -> GIRA_DENTRO.
  - else -> PROCURA.
- Turn counter:
  - If the candidate next state is GIRA_FORA/GIRA_DENTRO and turn counter == MAX_GIROS-1: go to RECUPERA instead, clear turn counter, load recovery counter with REC_TICKS-1.
  - Otherwise, a turning candidate increments the turn counter.
  - A non-turning next state clears it.
- RECUPERA:
  - Sensors are ignored (filters still update).
  - Each tick, recovery counter==0 -> PROCURA; otherwise decrement.
  - Dwell is exactly REC_TICKS ticks.
- Moore outputs (enable=1, not in reset):
  - PROCURA: avancar=1, girar=0.
  - SEGUE: avancar=1, girar=0.
  - GIRA_FORA: avancar=0, girar=1, sentido=~lado_q.
  - GIRA_DENTRO: avancar=1, girar=1, sentido=lado_q (arc back to the wall).
  - RECUPERA: avancar=0, girar=1, sentido=~lado_q, preso=1.
- Sensor-to-state latency: a raw change stable from tick k is seen by the FSM at tick k+DEB_LEN-1.
- Simultaneous h=1, w=1: GIRA_FORA wins.
- A lado change mid-turn flips sentido one tick later; the state is unaffected.
- Reset mid-recovery returns to PROCURA with preso=0 immediately.
- Counter widths are sized by $clog2 of the parameters. There is no overflow path because the turn counter never exceeds MAX_GIROS-1.

Test Plan:
Defaults unless stated; T = one tick = 3 clocks.
- Reset then enable=1, head=0, wall=0 -> estado=0, avancar=1, girar=0, sentido=0, preso=0; reset asserted mid-tick -> all outputs 0 asynchronously.
- wall=1 held 2T -> estado=1 (SEGUE) at 2nd tick. A 1-tick wall glitch -> estado stays 0, proving debounce.
- From SEGUE with lado=0: head=1 for 2T -> estado=2, girar=1, avancar=0, sentido=1. Repeat with lado=1 -> sentido=0.
- From SEGUE: wall=0 for 2T -> estado=3, avancar=1, girar=1, sentido=lado_q. wall=1 again for 2T -> estado=1.
- head=1 held indefinitely -> GIRA_FORA for 3 ticks, then estado=4 with preso=1 for exactly 2 ticks, then PROCURA; the cycle repeats while head stays 1.
- enable=0 for 5T while in GIRA_FORA -> all outputs 0, turn counter held. enable=1 -> resumes GIRA_FORA, with recovery after the remaining turn count.
